// File: rtl/uart_fifo_tx_if.sv
// FIFO read port between a byte FIFO (slave) and the UART transmitter that pops it (master).
interface uart_fifo_tx_if;
  logic [7:0] fifo_data;
  logic       fifo_isData;
  logic       fifo_oe;

  modport master (
    input  fifo_data,
    input  fifo_isData,
    output fifo_oe
  );

  modport slave (
    output fifo_data,
    output fifo_isData,
    input  fifo_oe
  );
endinterface

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining a byte FIFO: start, 8 data bits LSB first, optional parity, stop bits.
// Optional parity bit and parityOdd port are enabled by defining UART_TX_PARITY_EN.
module uart_fifo_tx #(
  parameter int CLOCK_SCALE_WIDTH = 16,
  parameter int STOP_BITS         = 1   // 1 or 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CLOCK_SCALE_WIDTH-1:0] clockScale,
`ifdef UART_TX_PARITY_EN
  input  logic                         parityOdd,
`endif
  uart_fifo_tx_if.master               rd,
  output logic                         tx,
  output logic                         busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [CLOCK_SCALE_WIDTH-1:0] PERIOD_ONE = CLOCK_SCALE_WIDTH'(1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t                       state;
  logic [2:0]                   bitCnt;
  logic [CLOCK_SCALE_WIDTH-1:0] periodCnt;
  logic [7:0]                   shiftReg;
  logic                         bitEnd;
`ifdef UART_TX_PARITY_EN
  logic                         parityAcc;
`endif

  assign bitEnd = (periodCnt == '0);

  // NOTE: every register here is updated with <= so all branches see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      rd.fifo_oe <= 1'b0;
      busy       <= 1'b0;
      bitCnt     <= '0;
      periodCnt  <= '0;
      shiftReg   <= '0;
`ifdef UART_TX_PARITY_EN
      parityAcc  <= 1'b0;
`endif
    end else begin
      rd.fifo_oe <= 1'b0;

      if (state != IDLE) begin
        periodCnt <= bitEnd ? clockScale : periodCnt - PERIOD_ONE;
      end

      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          if (enable && rd.fifo_isData) begin
            shiftReg   <= rd.fifo_data;
`ifdef UART_TX_PARITY_EN
            parityAcc  <= ^rd.fifo_data;
`endif
            rd.fifo_oe <= 1'b1;
            tx         <= 1'b0;
            busy       <= 1'b1;
            periodCnt  <= clockScale;
            state      <= START;
          end
        end

        START: begin
          if (bitEnd) begin
            tx       <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitCnt   <= '0;
            state    <= DATA;
          end
        end

        DATA: begin
          if (bitEnd) begin
            if (bitCnt == 3'd7) begin
              bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
              tx     <= parityAcc ^ parityOdd;
              state  <= PARITY;
`else
              tx     <= 1'b1;
              state  <= STOP;
`endif
            end else begin
              tx       <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
              bitCnt   <= bitCnt + 3'd1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bitEnd) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif

        STOP: begin
          if (bitEnd) begin
            // Leaving STOP drops busy; the following IDLE cycle is the mandatory inter-frame gap.
            if (bitCnt == LAST_STOP) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              bitCnt <= bitCnt + 3'd1;
            end
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_fifo_tx.md
# uart_fifo_tx

UART transmitter that drains a byte FIFO and serialises each byte onto a single `tx` line. It is the consumer end of the FIFO read interface (`isData`/`oe`/`dataOut`): it pops one word per frame and emits start, data (LSB first), optional parity, and stop bits. It sits between a peripheral's TX FIFO and the pad.

## Interface
- `CLOCK_SCALE_WIDTH`, 16, width of the `clockScale` input.
- `STOP_BITS`, 1, stop bits per frame; legal values are 1 or 2.
- `clk` input 1: the only clock. All logic is on `posedge clk`.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: allows new frames to start. It does not abort a frame in progress.
- `clockScale` input CLOCK_SCALE_WIDTH: bit period is `clockScale+1` clk cycles. It is sampled at every bit boundary.
- `fifo_data` input 8: FIFO head word (FIFO `dataOut`).
- `fifo_isData` input 1: the FIFO is non-empty.
- `fifo_oe` output 1: one-cycle pop request to the FIFO.
- `tx` output 1: serial output; idles high.
- `busy` output 1: high while a frame is in progress.
- `parityOdd` input 1: present only with `UART_TX_PARITY_EN`.

## Operation
- Reset values: `tx`=1, `fifo_oe`=0, `busy`=0, state IDLE, bit counter 0, period counter 0, shift register 0x00.
- State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:** `tx`=1. On a posedge with `enable && fifo_isData`, the block registers all of the following together:
  - shift register ← `fifo_data`;
  - `fifo_oe` ← 1;
  - `tx` ← 0;
  - state ← START;
  - period counter ← `clockScale`.
- `fifo_oe` is high for exactly one cycle per frame.
- **START:** `tx`=0 for one bit period.
- **DATA:** 8 bit periods. `tx` = shift[0], then the register shifts right. Bit counter runs 0..7.
- **PARITY:** one bit period, present only with the macro (see Configuration).
- **STOP:** `tx`=1 for `STOP_BITS` bit periods, then state ← IDLE.
- `busy` = (state != IDLE), registered together with the state.
- Period counter:
  - loaded with `clockScale` at each bit start and decremented each cycle;
  - a bit boundary occurs when it reads 0;
  - all arithmetic is modulo 2^CLOCK_SCALE_WIDTH;
  - `clockScale`=0 gives 1 cycle per bit.
- FIFO pop latency is 2 cycles (`isData` and `dataOut` settle by then). The minimum frame is 10 cycles, so `fifo_isData` is never re-sampled before it is valid. No separate cooldown is needed.
- `enable` falling mid-frame: the current frame completes and no new frame starts.
- `fifo_isData` falling mid-frame: ignored.
- Reset mid-frame: every output returns to its reset value immediately and asynchronously. The already-popped byte is discarded.
- `clockScale` changing mid-frame: takes effect at the next bit boundary.

## Timing
- Edge E samples `fifo_isData`=1 in IDLE.
- After E: `tx` is low and `fifo_oe` is high. `fifo_oe` returns low after E+1.
- Data bit n occupies cycles starting at E + (n+1)·(clockScale+1), through the following `clockScale+1` cycles.
- Frame length in cycles is `(10 + P + STOP_BITS − 1)·(clockScale+1)`, where P=1 with the parity macro and P=0 without.
- Back-to-back frames: after the last STOP cycle the block spends exactly one IDLE cycle (`tx`=1, `busy`=0), then the next start bit begins.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the `parityOdd` port exists;
  - PARITY state is inserted after DATA for one bit period;
  - `tx` = XOR of the 8 data bits XOR `parityOdd`, i.e. even parity when `parityOdd`=0.
- `UART_TX_PARITY_EN` undefined: no port, no state, 8N`STOP_BITS` frames.

## Test plan
- Single byte, `clockScale`=3, FIFO holds 0xA5:
  - `fifo_oe` is a single 1-cycle pulse;
  - `tx` sequence is 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles;
  - `busy` is high for 40 cycles.
- Empty FIFO, `enable`=1 for 100 cycles: `tx`=1, `fifo_oe`=0, `busy`=0 throughout.
- Two bytes 0x00 then 0xFF, `clockScale`=0:
  - two `fifo_oe` pulses 11 cycles apart;
  - `tx`=1 for exactly 2 cycles between the frames (stop bit plus one IDLE cycle).
- `enable`=0 with FIFO non-empty: no pop and `tx` stays high. Raise `enable`: the frame starts 1 cycle later.
- Assert `rst` during data bit 3 of 0x5A:
  - `tx`=1, `busy`=0, `fifo_oe`=0 immediately, without waiting for a clock edge;
  - after release, the next FIFO byte is sent, not 0x5A.
- With `UART_TX_PARITY_EN`, 0x07: `parityOdd`=0 gives parity bit 1; `parityOdd`=1 gives parity bit 0; the frame is 11 bit periods.
